// File: rtl/mcu_bus_pkg.sv
// Shared types and helpers for the DW8051 external-bus multiplexer.
package mcu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } bus_state_e;

  localparam logic [7:0] ERR_DATA_DFLT = 8'hFF;

  // Width of a slave index; never below one bit so single-slave builds stay legal.
  function automatic int slv_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mcu_addr_decode.sv
// Combinational window decode: processor address -> hit, one-hot slave select, local offset.
module mcu_addr_decode
  import mcu_bus_pkg::*;
#(
  parameter int              NUM_SLV = 4,
  parameter int              ADDR_W  = 16,
  parameter int              SLV_AW  = 7,
  parameter logic [ADDR_W-1:0] BASE  = 16'h8000
) (
  input  logic [ADDR_W-1:0]  mem_addr,
  output logic               hit,
  output logic [NUM_SLV-1:0] sel,
  output logic [SLV_AW-1:0]  local_addr
);

  localparam int IDX_W = slv_idx_w(NUM_SLV);

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] window;
  logic [IDX_W-1:0]  idx;

  always_comb begin
    offset     = mem_addr - BASE;
    window     = offset >> SLV_AW;
    idx        = window[IDX_W-1:0];
    // Addresses below BASE wrap to large offsets, so the explicit compare is required.
    hit        = (mem_addr >= BASE) && (window < ADDR_W'(NUM_SLV));
    sel        = hit ? (NUM_SLV'(1) << idx) : '0;
    local_addr = offset[SLV_AW-1:0];
  end

endmodule

// File: rtl/mcu_xbus_mux.sv
// MOVX bus multiplexer: turns level strobes into one req/ack transaction per access,
// stretches the core with mem_wait, and bounds hung slaves with a timeout.
module mcu_xbus_mux
  import mcu_bus_pkg::*;
#(
  parameter int                NUM_SLV  = 4,
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 8,
  parameter int                SLV_AW   = 7,
  parameter logic [ADDR_W-1:0] BASE     = 16'h8000,
  parameter int                TIMEOUT  = 15,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DFLT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_data_out,
  output logic [DATA_W-1:0]         mem_data_in,
  input  logic                      mem_wr_n,
  input  logic                      mem_rd_n,
  output logic                      mem_wait,
  output logic [NUM_SLV-1:0]        slv_req,
  output logic                      slv_we,
  output logic [SLV_AW-1:0]         slv_addr,
  output logic [DATA_W-1:0]         slv_wdata,
  input  logic [NUM_SLV*DATA_W-1:0] slv_rdata,
  input  logic [NUM_SLV-1:0]        slv_ack,
  output logic                      bus_err,
  input  logic                      err_clr,
  output logic [1:0]                dbg_state
);

  // Handshake: slv_req[i] rises for exactly one transaction and holds until the
  // cycle slv_ack[i] is sampled high (or timeout); slv_we/slv_addr/slv_wdata are
  // stable throughout, and read data is taken from slv_rdata in the ack cycle.

  bus_state_e          state;
  logic                prev_rd_n, prev_wr_n;
  logic [7:0]          cnt;
  logic [7:0]          cnt_nxt;
  logic                dec_hit;
  logic [NUM_SLV-1:0]  dec_sel;
  logic [SLV_AW-1:0]   dec_local;
  logic                start, dual, ack_hit, tmo, set_err;
  logic [DATA_W-1:0]   rdata_sel;

  mcu_addr_decode #(
    .NUM_SLV (NUM_SLV),
    .ADDR_W  (ADDR_W),
    .SLV_AW  (SLV_AW),
    .BASE    (BASE)
  ) u_decode (
    .mem_addr   (mem_addr),
    .hit        (dec_hit),
    .sel        (dec_sel),
    .local_addr (dec_local)
  );

  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (slv_req[i]) rdata_sel = rdata_sel | slv_rdata[i*DATA_W +: DATA_W];
    end
    start   = (state == IDLE) && (!mem_rd_n || !mem_wr_n) && prev_rd_n && prev_wr_n;
    dual    = !mem_rd_n && !mem_wr_n;
    ack_hit = |(slv_ack & slv_req);
    cnt_nxt = cnt + 8'd1;
    tmo     = (state == ACCESS) && !ack_hit && (cnt_nxt == 8'(TIMEOUT));
    set_err = (start && dual) || tmo;
  end

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      // Reset both samples low so a strobe held across reset cannot start an access.
      prev_rd_n   <= 1'b0;
      prev_wr_n   <= 1'b0;
      cnt         <= '0;
      slv_req     <= '0;
      mem_wait    <= 1'b0;
      mem_data_in <= '0;
      slv_we      <= 1'b0;
      slv_addr    <= '0;
      slv_wdata   <= '0;
      bus_err     <= 1'b0;
    end else begin
      prev_rd_n <= mem_rd_n;
      prev_wr_n <= mem_wr_n;
      if (set_err)      bus_err <= 1'b1;
      else if (err_clr) bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            slv_addr  <= dec_local;
            slv_wdata <= mem_data_out;
            slv_we    <= !mem_wr_n;
            if (dual) begin
              mem_data_in <= ERR_DATA;
              state       <= DONE;
            end else if (dec_hit) begin
              slv_req  <= dec_sel;
              mem_wait <= 1'b1;
              cnt      <= '0;
              state    <= ACCESS;
            end else begin
              mem_data_in <= '0;
              state       <= DONE;
            end
          end
        end
        ACCESS: begin
          if (ack_hit) begin
            if (!slv_we) mem_data_in <= rdata_sel;
            slv_req  <= '0;
            mem_wait <= 1'b0;
            state    <= DONE;
          end else if (tmo) begin
            mem_data_in <= ERR_DATA;
            slv_req     <= '0;
            mem_wait    <= 1'b0;
            state       <= DONE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        DONE: begin
          if (mem_rd_n && mem_wr_n) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_xbus_mux.sv
// Directed bench for mcu_xbus_mux: windows, write, timeout, unmapped, dual strobe, reset.
module tb_mcu_xbus_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_out;
  logic [7:0]  mem_data_in;
  logic        mem_wr_n, mem_rd_n, mem_wait;
  logic [3:0]  slv_req;
  logic        slv_we;
  logic [6:0]  slv_addr;
  logic [7:0]  slv_wdata;
  logic [31:0] slv_rdata;
  logic [3:0]  slv_ack;
  logic        bus_err, err_clr;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  int         waits;
  logic [3:0] req_seen;
  logic       we_seen;

  always #5 clk = ~clk;

  mcu_xbus_mux dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .mem_data_in  (mem_data_in),
    .mem_wr_n     (mem_wr_n),
    .mem_rd_n     (mem_rd_n),
    .mem_wait     (mem_wait),
    .slv_req      (slv_req),
    .slv_we       (slv_we),
    .slv_addr     (slv_addr),
    .slv_wdata    (slv_wdata),
    .slv_rdata    (slv_rdata),
    .slv_ack      (slv_ack),
    .bus_err      (bus_err),
    .err_clr      (err_clr),
    .dbg_state    (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Compare mem_data_in against the oldest expected read-back value.
  task automatic check_rdata(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    check(tag, mem_data_in, e);
  endtask

  // One MOVX access; the selected slave acks on wait cycle ack_after (0 = never)
  // while its neighbour acks every cycle with junk data.
  task automatic run_access(input logic [15:0] addr, input logic is_wr, input logic [7:0] wd,
                            input int ack_after, input int slv, input logic [7:0] rd);
    mem_addr     = addr;
    mem_data_out = wd;
    if (is_wr) mem_wr_n = 1'b0;
    else       mem_rd_n = 1'b0;
    cyc();
    req_seen = slv_req;
    we_seen  = slv_we;
    waits    = 0;
    while (mem_wait && waits < 100) begin
      waits++;
      slv_ack = '0;
      slv_ack[(slv + 1) % 4] = 1'b1;
      if (waits == ack_after) begin
        slv_ack[slv] = 1'b1;
        slv_rdata[slv*8 +: 8] = rd;
      end
      cyc();
      slv_ack   = '0;
      slv_rdata = {4{8'hEE}};
    end
    if (waits >= 100) check("wait_bound", 32'(waits), 32'd0);
  endtask

  task automatic release_strobes();
    mem_rd_n = 1'b1;
    mem_wr_n = 1'b1;
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; mem_addr = '0; mem_data_out = '0; mem_wr_n = 1'b1; mem_rd_n = 1'b1;
    slv_rdata = {4{8'hEE}}; slv_ack = '0; err_clr = 1'b0;
    cyc(); cyc();
    check("rst_req", slv_req, 4'b0);
    check("rst_wait", mem_wait, 1'b0);
    check("rst_data", mem_data_in, 8'h00);
    check("rst_err", bus_err, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    rst_n = 1'b1;
    cyc();

    // Read window 2, slave acks on the third wait cycle.
    exp_q.push_back(8'h5A);
    run_access(16'h8105, 1'b0, 8'h00, 3, 2, 8'h5A);
    check("rd2_req", req_seen, 4'b0100);
    check("rd2_we", we_seen, 1'b0);
    check("rd2_waits", 32'(waits), 32'd3);
    check("rd2_addr", slv_addr, 7'h05);
    check_rdata("rd2_data");
    check("rd2_err", bus_err, 1'b0);
    check("rd2_req_off", slv_req, 4'b0);
    release_strobes();

    // Write window 0, ack on first wait cycle; read-back register untouched.
    exp_q.push_back(8'h5A);
    run_access(16'h8000, 1'b1, 8'hC3, 1, 0, 8'h99);
    check("wr0_req", req_seen, 4'b0001);
    check("wr0_we", we_seen, 1'b1);
    check("wr0_waits", 32'(waits), 32'd1);
    check("wr0_wdata", slv_wdata, 8'hC3);
    check_rdata("wr0_data");
    release_strobes();

    // No ack from window 2: timeout after 15 cycles.
    exp_q.push_back(8'hFF);
    run_access(16'h8110, 1'b0, 8'h00, 0, 2, 8'h00);
    check("tmo_req", req_seen, 4'b0100);
    check("tmo_waits", 32'(waits), 32'd15);
    check_rdata("tmo_data");
    check("tmo_err", bus_err, 1'b1);
    release_strobes();
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    check("clr_err", bus_err, 1'b0);

    // Ack on the very cycle the count reaches TIMEOUT: ack wins.
    exp_q.push_back(8'h3C);
    run_access(16'h8190, 1'b0, 8'h00, 15, 3, 8'h3C);
    check("edge_req", req_seen, 4'b1000);
    check("edge_waits", 32'(waits), 32'd15);
    check_rdata("edge_data");
    check("edge_err", bus_err, 1'b0);
    release_strobes();

    // Unmapped low address returns zero without any request.
    exp_q.push_back(8'h00);
    run_access(16'h1234, 1'b0, 8'h00, 0, 0, 8'h00);
    check("unm_req", req_seen, 4'b0);
    check("unm_waits", 32'(waits), 32'd0);
    check_rdata("unm_data");
    check("unm_err", bus_err, 1'b0);
    release_strobes();

    // Last byte of window 3.
    exp_q.push_back(8'hA5);
    run_access(16'h81FF, 1'b0, 8'h00, 1, 3, 8'hA5);
    check("top_req", req_seen, 4'b1000);
    check("top_addr", slv_addr, 7'h7F);
    check_rdata("top_data");
    release_strobes();

    // Beyond the last window.
    exp_q.push_back(8'h00);
    run_access(16'h8300, 1'b0, 8'h00, 0, 0, 8'h00);
    check("hi_req", req_seen, 4'b0);
    check_rdata("hi_data");
    release_strobes();

    exp_q.push_back(8'h11);
    run_access(16'h8000, 1'b0, 8'h00, 2, 0, 8'h11);
    check("w0_addr", slv_addr, 7'h00);
    check_rdata("w0_data");
    release_strobes();

    // Just below BASE.
    exp_q.push_back(8'h00);
    run_access(16'h7FFF, 1'b0, 8'h00, 0, 0, 8'h00);
    check("lo_req", req_seen, 4'b0);
    check_rdata("lo_data");
    release_strobes();

    // Both strobes low together.
    mem_addr = 16'h8105; mem_rd_n = 1'b0; mem_wr_n = 1'b0;
    cyc();
    check("dual_req", slv_req, 4'b0);
    check("dual_wait", mem_wait, 1'b0);
    check("dual_data", mem_data_in, 8'hFF);
    check("dual_err", bus_err, 1'b1);
    release_strobes();

    // Reset in the middle of an access, with the strobe held low throughout.
    mem_addr = 16'h8080; mem_rd_n = 1'b0;
    cyc();
    check("mid_req", slv_req, 4'b0010);
    rst_n = 1'b0;
    cyc();
    check("mid_rst_req", slv_req, 4'b0);
    check("mid_rst_wait", mem_wait, 1'b0);
    check("mid_rst_data", mem_data_in, 8'h00);
    check("mid_rst_err", bus_err, 1'b0);
    rst_n = 1'b1;
    cyc(); cyc(); cyc();
    check("held_req", slv_req, 4'b0);
    check("held_state", dbg_state, 2'd0);
    mem_rd_n = 1'b1; cyc();
    mem_rd_n = 1'b0; cyc();
    check("restart_req", slv_req, 4'b0010);
    slv_ack[1] = 1'b1; slv_rdata[15:8] = 8'h77;
    cyc();
    slv_ack = '0; slv_rdata = {4{8'hEE}};
    check("restart_data", mem_data_in, 8'h77);
    check("restart_wait", mem_wait, 1'b0);
    release_strobes();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
